// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the single-port SRAM requester controller.
package sram_ctrl_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_resp_hold.sv
// Read-response path: tracks the read in flight, parks its data under backpressure,
// and tells the request side whether another read may be accepted.
module sram_resp_hold
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 80
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_fire_i,
  input  logic              resp_ready_i,
  input  logic [DATA_W-1:0] sram_q_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              rd_permit_o
);

  logic              inflight_q, inflight_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      inflight_q   <= inflight_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  // Q is only valid for one cycle, so an unaccepted read result must be parked now.
  always_comb begin
    inflight_d   = rd_fire_i;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (hold_valid_q && resp_ready_i) begin
      hold_valid_d = 1'b0;
    end else if (inflight_q && !hold_valid_q && !resp_ready_i) begin
      hold_valid_d = 1'b1;
      hold_data_d  = sram_q_i;
    end
  end

  assign resp_valid_o = hold_valid_q | inflight_q;
  assign resp_rdata_o = hold_valid_q ? hold_data_q : sram_q_i;
  assign rd_permit_o  = ~hold_valid_q & ~(inflight_q & ~resp_ready_i);

endmodule

// File: rtl/sram_sp_ctrl.sv
// Requester-side controller for a single-port SRAM macro (CEB/WEB active-low, 1-cycle read latency).
// Define SRAM_CTRL_INIT_EN to sweep INIT_VALUE into every word after reset before accepting requests.
module sram_sp_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
`ifdef SRAM_CTRL_INIT_EN
  , parameter logic [DATA_W-1:0] INIT_VALUE = '0
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_CEB,
  output logic              sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_D,
  input  logic [DATA_W-1:0] sram_Q
);

  if (ADDR_W != clog2(DEPTH)) begin : g_addr_w_check
    $error("sram_sp_ctrl: ADDR_W does not match DEPTH");
  end

  state_e state_q, state_d;
  logic   run;
  logic   fire;
  logic   rd_fire;
  logic   rd_permit;

`ifdef SRAM_CTRL_INIT_EN
  localparam logic [ADDR_W:0] INIT_END = (ADDR_W+1)'(DEPTH);
  logic [ADDR_W:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) init_cnt_q <= '0;
    else       init_cnt_q <= init_cnt_d;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef SRAM_CTRL_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef SRAM_CTRL_INIT_EN
        init_cnt_d = init_cnt_q + (ADDR_W+1)'(1);
        if (init_cnt_d == INIT_END) state_d = ST_RUN;
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign init_done = run;
  assign req_ready = run & (req_write | rd_permit);
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_write;

  // The sweep owns the pins during INIT; reset gates it so the macro is idle while reset is held.
  always_comb begin
    sram_CEB = ~fire;
    sram_WEB = ~(fire & req_write);
    sram_A   = req_addr;
    sram_D   = req_wdata;
`ifdef SRAM_CTRL_INIT_EN
    if (state_q == ST_INIT && !reset) begin
      sram_CEB = 1'b0;
      sram_WEB = 1'b0;
      sram_A   = init_cnt_q[ADDR_W-1:0];
      sram_D   = INIT_VALUE;
    end
`endif
  end

  sram_resp_hold #(
    .DATA_W(DATA_W)
  ) u_resp_hold (
    .clock       (clock),
    .reset       (reset),
    .rd_fire_i   (rd_fire),
    .resp_ready_i(resp_ready),
    .sram_q_i    (sram_Q),
    .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata),
    .rd_permit_o (rd_permit)
  );

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Directed self-checking bench for sram_sp_ctrl with a behavioural single-port macro model.
// Also covers the init sweep when built with SRAM_CTRL_INIT_EN.
module tb_sram_sp_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [79:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [79:0] resp_rdata;
  logic        init_done;
  logic        sram_CEB;
  logic        sram_WEB;
  logic [7:0]  sram_A;
  logic [79:0] sram_D;
  logic [79:0] sram_Q;

  int n_cmp = 0;
  int n_err = 0;

  sram_sp_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .init_done (init_done),
    .sram_CEB  (sram_CEB),
    .sram_WEB  (sram_WEB),
    .sram_A    (sram_A),
    .sram_D    (sram_D),
    .sram_Q    (sram_Q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model: Q is garbage on every cycle that is not a read, so stale-Q use shows up.
  logic [79:0] mem [0:255];
  always @(posedge clock) begin
    if (!sram_CEB && sram_WEB) sram_Q <= mem[sram_A];
    else                       sram_Q <= {16'hdead, $urandom(), $urandom()};
    if (!sram_CEB && !sram_WEB) mem[sram_A] <= sram_D;
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [7:0] a,
                       input logic [79:0] d, input logic rr);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = rr;
    #1;
  endtask

  task automatic cyc(input logic v, input logic w, input logic [7:0] a,
                     input logic [79:0] d, input logic rr);
    @(negedge clock);
    drive(v, w, a, d, rr);
  endtask

  task automatic wait_init(input int exp_cycles);
    int cnt;
    cnt = 0;
`ifdef SRAM_CTRL_INIT_EN
    check("init_first_addr", 80'(sram_A), 80'd0);
    check("init_first_ceb", 80'(sram_CEB), 80'd0);
`endif
    while (!init_done && cnt < 600) begin
      @(negedge clock);
      #1;
      cnt++;
    end
    check("init_cycles", 80'(cnt), 80'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 80'h0, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    check("rst_req_ready", 80'(req_ready), 80'd0);
    check("rst_resp_valid", 80'(resp_valid), 80'd0);
    check("rst_ceb", 80'(sram_CEB), 80'd1);
    check("rst_web", 80'(sram_WEB), 80'd1);
    check("rst_init_done", 80'(init_done), 80'd0);

`ifdef SRAM_CTRL_INIT_EN
    reset = 1'b0;
    repeat (100) begin
      @(negedge clock);
      #1;
    end
    check("sweep_addr_100", 80'(sram_A), 80'd100);
    check("sweep_req_ready", 80'(req_ready), 80'd0);
    reset = 1'b1;
    #1;
    check("sweep_rst_ceb", 80'(sram_CEB), 80'd1);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    wait_init(256);
    cyc(1'b1, 1'b0, 8'd255, 80'h0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("init_rd255_valid", 80'(resp_valid), 80'd1);
    check("init_rd255_data", resp_rdata, 80'h0);
`else
    reset = 1'b0;
    #1;
    wait_init(1);
`endif

    // write then read back
    cyc(1'b1, 1'b1, 8'd5, 80'h1234, 1'b1);
    check("wr5_ready", 80'(req_ready), 80'd1);
    check("wr5_ceb", 80'(sram_CEB), 80'd0);
    check("wr5_web", 80'(sram_WEB), 80'd0);
    check("wr5_addr", 80'(sram_A), 80'd5);
    cyc(1'b1, 1'b0, 8'd5, 80'h0, 1'b1);
    check("rd5_web", 80'(sram_WEB), 80'd1);
    check("rd5_no_resp_yet", 80'(resp_valid), 80'd0);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("rd5_resp_valid", 80'(resp_valid), 80'd1);
    check("rd5_data", resp_rdata, 80'h1234);
    check("idle_ceb", 80'(sram_CEB), 80'd1);

    // preload
    cyc(1'b1, 1'b1, 8'd1, 80'h11, 1'b1);
    cyc(1'b1, 1'b1, 8'd2, 80'h22, 1'b1);
    cyc(1'b1, 1'b1, 8'd3, 80'h33, 1'b1);
    cyc(1'b1, 1'b1, 8'd7, 80'h77, 1'b1);

    // back-to-back reads
    cyc(1'b1, 1'b0, 8'd1, 80'h0, 1'b1);
    check("b2b_ready0", 80'(req_ready), 80'd1);
    cyc(1'b1, 1'b0, 8'd2, 80'h0, 1'b1);
    check("b2b_ready1", 80'(req_ready), 80'd1);
    check("b2b_data1", resp_rdata, 80'h11);
    cyc(1'b1, 1'b0, 8'd3, 80'h0, 1'b1);
    check("b2b_ready2", 80'(req_ready), 80'd1);
    check("b2b_data2", resp_rdata, 80'h22);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("b2b_valid3", 80'(resp_valid), 80'd1);
    check("b2b_data3", resp_rdata, 80'h33);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("b2b_drained", 80'(resp_valid), 80'd0);

    // backpressure: read A1, consumer stalls 4 cycles, write A1 meanwhile
    cyc(1'b1, 1'b0, 8'd1, 80'h0, 1'b0);
    check("bp_rd_ready", 80'(req_ready), 80'd1);
    cyc(1'b1, 1'b0, 8'd2, 80'h0, 1'b0);
    check("bp_inflight_valid", 80'(resp_valid), 80'd1);
    check("bp_inflight_data", resp_rdata, 80'h11);
    check("bp_rd_blocked1", 80'(req_ready), 80'd0);
    cyc(1'b1, 1'b1, 8'd1, 80'haa, 1'b0);
    check("bp_wr_accepted", 80'(req_ready), 80'd1);
    check("bp_wr_ceb", 80'(sram_CEB), 80'd0);
    check("bp_hold_data1", resp_rdata, 80'h11);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b0);
    check("bp_hold_data2", resp_rdata, 80'h11);
    cyc(1'b1, 1'b0, 8'd1, 80'h0, 1'b0);
    check("bp_rd_blocked2", 80'(req_ready), 80'd0);
    check("bp_hold_valid", 80'(resp_valid), 80'd1);
    cyc(1'b1, 1'b0, 8'd1, 80'h0, 1'b1);
    check("bp_release_data", resp_rdata, 80'h11);
    check("bp_release_valid", 80'(resp_valid), 80'd1);
    check("bp_release_ready", 80'(req_ready), 80'd0);
    cyc(1'b1, 1'b0, 8'd1, 80'h0, 1'b1);
    check("bp_resume_ready", 80'(req_ready), 80'd1);
    check("bp_resume_novalid", 80'(resp_valid), 80'd0);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("bp_new_data", resp_rdata, 80'haa);

    // read A7 then write A9 while stalled
    cyc(1'b1, 1'b0, 8'd7, 80'h0, 1'b0);
    cyc(1'b1, 1'b1, 8'd9, 80'h99, 1'b0);
    check("rw_wr_ready", 80'(req_ready), 80'd1);
    check("rw_data_t1", resp_rdata, 80'h77);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b0);
    check("rw_hold_data", resp_rdata, 80'h77);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("rw_take_data", resp_rdata, 80'h77);
    cyc(1'b1, 1'b0, 8'd9, 80'h0, 1'b1);
    check("rw_hold_cleared", 80'(resp_valid), 80'd0);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("rw_rd9_data", resp_rdata, 80'h99);

    // read-after-write, consecutive cycles
    cyc(1'b1, 1'b1, 8'd20, 80'h0123_4567_89ab_cdef_beef, 1'b1);
    cyc(1'b1, 1'b0, 8'd20, 80'h0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("raw_data", resp_rdata, 80'h0123_4567_89ab_cdef_beef);

    // reset with a response parked in hold
    cyc(1'b1, 1'b0, 8'd5, 80'h0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b0);
    cyc(1'b1, 1'b1, 8'd3, 80'h55, 1'b0);
    check("hrst_pre_valid", 80'(resp_valid), 80'd1);
    check("hrst_pre_data", resp_rdata, 80'h1234);
    reset = 1'b1;
    #1;
    check("hrst_resp_valid", 80'(resp_valid), 80'd0);
    check("hrst_ceb", 80'(sram_CEB), 80'd1);
    check("hrst_req_ready", 80'(req_ready), 80'd0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
`ifdef SRAM_CTRL_INIT_EN
    wait_init(256);
    check("hrst_stale", 80'(resp_valid), 80'd0);
`else
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
      check("hrst_stale", 80'(resp_valid), 80'd0);
    end
    cyc(1'b1, 1'b0, 8'd5, 80'h0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 80'h0, 1'b1);
    check("hrst_rd5_data", resp_rdata, 80'h1234);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
